// File: rtl/c_pkt_gnt_hold.sv
// c_pkt_gnt_hold: holds an arbiter grant on the winning input until its packet's tail flit transfers.
module c_pkt_gnt_hold #(
    parameter int num_ports   = 8,
    parameter int max_pkt_len = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              active,
    input  logic [0:num_ports-1]              req,
    input  logic [0:num_ports-1]              head,
    input  logic [0:num_ports-1]              tail,
    input  logic                              out_ready,
    output logic [0:num_ports-1]              arb_req,
    input  logic [0:num_ports-1]              arb_gnt,
    output logic                              arb_update,
    output logic [0:num_ports-1]              sel,
    output logic [$clog2(num_ports)-1:0]      sel_idx,
    output logic                              xfer,
    output logic                              len_err
);
    localparam int port_idx_width = $clog2(num_ports);
    localparam int cnt_width      = $clog2(max_pkt_len);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               fsm, fsm_nxt;
    logic [0:num_ports-1] owner, owner_nxt;
    logic [cnt_width-1:0] cnt, cnt_nxt;
    logic                 len_err_nxt;
    logic                 tail_hit;
    logic                 at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm     <= IDLE;
            owner   <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            fsm     <= fsm_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            len_err <= len_err_nxt;
        end
    end

    always_comb begin
        arb_req     = '0;
        arb_update  = 1'b0;
        sel         = '0;
        fsm_nxt     = fsm;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        len_err_nxt = len_err;
        if (active && fsm == IDLE) begin
            arb_req    = out_ready ? (req & head) : '0;
            sel        = arb_gnt;
            arb_update = |arb_gnt;
        end else if (active) begin
            sel = out_ready ? (owner & req) : '0;
        end
        xfer     = |sel;
        tail_hit = |(sel & tail);
        at_limit = cnt == cnt_width'(max_pkt_len - 1);
        // a single-flit packet never takes the lock
        if (xfer && fsm == IDLE && !tail_hit) begin
            fsm_nxt   = LOCKED;
            owner_nxt = sel;
            cnt_nxt   = cnt_width'(1);
        end else if (xfer && fsm == LOCKED && (tail_hit || at_limit)) begin
            fsm_nxt     = IDLE;
            owner_nxt   = '0;
            cnt_nxt     = '0;
            len_err_nxt = len_err | ~tail_hit;
        end else if (xfer && fsm == LOCKED) begin
            cnt_nxt = cnt + cnt_width'(1);
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < num_ports; i++)
            if (sel[i]) sel_idx = port_idx_width'(i);
    end

    gnt_legal: assert property (@(posedge clk) disable iff (reset)
        $onehot0(arb_gnt) && ((arb_gnt & ~arb_req) == '0));

endmodule

// File: tb/tb_c_pkt_gnt_hold.sv
// tb_c_pkt_gnt_hold: vector table, directed corner sequences and random traffic against a packet-level model.
module tb_c_pkt_gnt_hold;
    localparam int N  = 8;
    localparam int ML = 16;
    localparam int IW = $clog2(N);

    logic clk = 1'b0, reset = 1'b1, active = 1'b1, out_ready = 1'b0;
    logic [0:N-1] req = '0, head = '0, tail = '0;
    logic [0:N-1] arb_req, arb_gnt, sel;
    logic arb_update, xfer, len_err;
    logic [IW-1:0] sel_idx;
    int prio = 0;
    int checks = 0, errors = 0;

    int m_owner = -1, m_cnt = 0;
    bit m_err = 1'b0;

    logic [0:N-1] s_req, s_sel;
    logic s_xfer, s_upd, s_err;
    logic [IW-1:0] s_idx;

    always #5 clk = ~clk;

    // rotating-priority arbiter starting at port prio
    function automatic logic [0:N-1] arb(input logic [0:N-1] r, input int pr);
        logic [0:N-1] g = '0;
        for (int k = 0; k < N; k++) begin
            int p = (pr + k) % N;
            if (g == '0 && r[p]) g[p] = 1'b1;
        end
        return g;
    endfunction

    assign arb_gnt = arb(arb_req, prio);

    c_pkt_gnt_hold #(.num_ports(N), .max_pkt_len(ML)) dut (
        .clk(clk), .reset(reset), .active(active), .req(req), .head(head), .tail(tail),
        .out_ready(out_ready), .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_update(arb_update),
        .sel(sel), .sel_idx(sel_idx), .xfer(xfer), .len_err(len_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [0:N-1] e_req, e_sel;
        int p;
        @(negedge clk);
        e_req = '0;
        e_sel = '0;
        if (active && m_owner < 0) begin
            e_req = out_ready ? (req & head) : '0;
            e_sel = arb(e_req, prio);
        end else if (active && out_ready && req[m_owner]) begin
            e_sel[m_owner] = 1'b1;
        end
        p = 0;
        for (int i = 0; i < N; i++) if (e_sel[i]) p = i;
        s_req = arb_req; s_sel = sel; s_xfer = xfer; s_upd = arb_update; s_err = len_err; s_idx = sel_idx;
        chk("arb_req", arb_req, e_req);
        chk("sel", sel, e_sel);
        chk("sel_idx", sel_idx, p);
        chk("xfer", xfer, |e_sel);
        chk("arb_update", arb_update, active && m_owner < 0 && (|e_sel));
        chk("len_err", len_err, m_err);
        if (reset) begin
            m_owner = -1; m_cnt = 0; m_err = 1'b0;
        end else if (|e_sel) begin
            if (m_owner < 0) begin
                if (!tail[p]) begin m_owner = p; m_cnt = 1; end
            end else begin
                m_cnt++;
                if (tail[p] || m_cnt == ML) begin
                    m_err = m_err | !tail[p];
                    m_owner = -1;
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic a, input logic o, input logic [0:N-1] r, input logic [0:N-1] h, input logic [0:N-1] t);
        active = a; out_ready = o; req = r; head = h; tail = t;
        cycle();
    endtask

    typedef struct {
        logic act; logic [0:N-1] r, h, t; logic ordy; int pr;
        logic [0:N-1] xr, xs; logic xx, xu, xe; int xi;
    } vec_t;

    localparam logic [0:N-1] P0 = 8'b10000000, P1 = 8'b01000000, P2 = 8'b00100000, P3 = 8'b00010000;
    localparam logic [0:N-1] P4 = 8'b00001000, P5 = 8'b00000100, P6 = 8'b00000010, P7 = 8'b00000001;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, P2, P2, P2, 1'b1, 0, P2, P2, 1'b1, 1'b1, 1'b0, 2};
        tbl[1] = '{1'b1, P1|P5, P1|P5, '0, 1'b1, 5, P1|P5, P5, 1'b1, 1'b1, 1'b0, 5};
        tbl[2] = '{1'b1, P1|P5, P1, '0, 1'b1, 5, '0, P5, 1'b1, 1'b0, 1'b0, 5};
        tbl[3] = '{1'b1, P1|P5, P1, '0, 1'b1, 5, '0, P5, 1'b1, 1'b0, 1'b0, 5};
        tbl[4] = '{1'b1, P1|P5, P1, P5, 1'b1, 5, '0, P5, 1'b1, 1'b0, 1'b0, 5};
        tbl[5] = '{1'b1, P1, P1, P1, 1'b1, 5, P1, P1, 1'b1, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b0, P1, P1, '0, 1'b1, 5, '0, '0, 1'b0, 1'b0, 1'b0, 0};
        tbl[7] = '{1'b1, P7, P7, '0, 1'b0, 0, '0, '0, 1'b0, 1'b0, 1'b0, 0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b1, '0, '0, '0);
        chk("reset arb_req", s_req, 0);
        chk("reset xfer", s_xfer, 0);
        chk("reset len_err", s_err, 0);

        for (int i = 0; i < 8; i++) begin
            prio = tbl[i].pr;
            step(tbl[i].act, tbl[i].ordy, tbl[i].r, tbl[i].h, tbl[i].t);
            chk($sformatf("vec%0d arb_req", i), s_req, tbl[i].xr);
            chk($sformatf("vec%0d sel", i), s_sel, tbl[i].xs);
            chk($sformatf("vec%0d xfer", i), s_xfer, tbl[i].xx);
            chk($sformatf("vec%0d arb_update", i), s_upd, tbl[i].xu);
            chk($sformatf("vec%0d len_err", i), s_err, tbl[i].xe);
            chk($sformatf("vec%0d sel_idx", i), s_idx, tbl[i].xi);
        end

        // stall mid-packet
        prio = 0;
        step(1'b1, 1'b1, P3, P3, '0);
        step(1'b1, 1'b1, P3, '0, '0);
        step(1'b1, 1'b0, P3, '0, '0);
        chk("stall1 xfer", s_xfer, 0);
        step(1'b1, 1'b0, P3, '0, '0);
        chk("stall2 xfer", s_xfer, 0);
        step(1'b1, 1'b1, P3, '0, '0);
        chk("post-stall xfer", s_xfer, 1);
        step(1'b1, 1'b1, P3, '0, P3);
        chk("stall tail sel", s_sel, P3);
        step(1'b1, 1'b1, '0, '0, '0);
        chk("stall len_err", s_err, 0);

        // overlong packet on port 0
        step(1'b1, 1'b1, P0, P0, '0);
        for (int i = 0; i < ML - 1; i++) begin
            step(1'b1, 1'b1, P0, '0, '0);
            chk("long xfer", s_xfer, 1);
        end
        step(1'b1, 1'b1, P0, P0, P0);
        chk("long len_err", s_err, 1);
        chk("long rearb update", s_upd, 1);

        // reset on the second flit
        step(1'b1, 1'b1, P4, P4, '0);
        reset = 1'b1;
        step(1'b1, 1'b1, P4, '0, '0);
        reset = 1'b0;
        step(1'b1, 1'b1, P6, P6, P6);
        chk("post-reset len_err", s_err, 0);
        chk("post-reset update", s_upd, 1);
        chk("post-reset sel", s_sel, P6);

        // inactive during lock
        step(1'b1, 1'b1, P2, P2, '0);
        step(1'b1, 1'b1, P2, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, P1|P2, P1, '0);
            chk("inactive xfer", s_xfer, 0);
        end
        step(1'b1, 1'b1, P1|P2, P1, '0);
        chk("resume sel", s_sel, P2);
        step(1'b1, 1'b1, P2, '0, P2);
        step(1'b1, 1'b1, '0, '0, '0);

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(99) == 0;
            prio = $urandom_range(N - 1);
            step($urandom_range(9) != 0, $urandom_range(4) != 0, N'($urandom), N'($urandom),
                 N'($urandom & $urandom & $urandom));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
